mem_io_unit: RTL and testbench

- Responder side of the CPU datapath memory interface.
- Serves instruction fetch, memory-stage loads/stores, call-stack push/pop and frame-buffer access, plus an independent video read port for the display controller.
- Owns main data memory, frame buffer, call stack and program memory.
- Program memory is writable from the 12-bit data port through a three-chunk staging mechanism.

---
 rtl/mem_io_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_io_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_unit.sv
// Memory responder for the CPU datapath: main memory, frame buffer, call stack and
// program memory behind one prioritised data port, plus fetch and video read ports.
module mem_io_unit #(
  parameter int unsigned MAIN_ADDR_W = 12,
  parameter int unsigned FB_ADDR_W   = 14,
  parameter int unsigned PROG_ADDR_W = 14,
  parameter int unsigned CSTK_ADDR_W = 8
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic [13:0]          prog_cntr_val,
  output logic [31:0]          mem_fetch_instruction,
  input  logic                 main_mem_en,
  input  logic                 prog_mem_en,
  input  logic                 fb_en,
  input  logic                 call_stk_en,
  input  logic                 mem_wen,
  input  logic [15:0]          mem_addr,
  input  logic [11:0]          write_data,
  output logic [11:0]          read_data,
  input  logic [7:0]           call_stk_addr,
  input  logic [13:0]          call_stk_write_data,
  output logic [13:0]          call_stk_read_data,
  input  logic [FB_ADDR_W-1:0] video_addr,
  output logic [11:0]          video_data,
  output logic                 bus_conflict,
  output logic                 prog_wr_err
);

  localparam int unsigned DATA_W     = 12;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned CSTK_W     = 14;
  localparam int unsigned MAIN_DEPTH = 1 << MAIN_ADDR_W;
  localparam int unsigned FB_DEPTH   = 1 << FB_ADDR_W;
  localparam int unsigned PROG_DEPTH = 1 << PROG_ADDR_W;
  localparam int unsigned CSTK_DEPTH = 1 << CSTK_ADDR_W;

  typedef enum logic [1:0] {RD_NONE, RD_MAIN, RD_FB, RD_PROG} rd_src_e;

  logic [DATA_W-1:0]  main_mem [0:MAIN_DEPTH-1];
  logic [DATA_W-1:0]  fb_mem   [0:FB_DEPTH-1];
  logic [INSTR_W-1:0] prog_mem [0:PROG_DEPTH-1];
  logic [CSTK_W-1:0]  cstk_mem [0:CSTK_DEPTH-1];

  logic [MAIN_ADDR_W-1:0] main_addr_c;
  logic [FB_ADDR_W-1:0]   fb_addr_c;
  logic [PROG_ADDR_W-1:0] prog_addr_c;
  logic [CSTK_ADDR_W-1:0] cstk_addr_c;
  logic [1:0]             chunk_c;
  logic [2:0]             en_cnt_c;

  rd_src_e     rd_src_c;
  logic        main_we_c, fb_we_c, prog_we_c, cstk_we_c, cstk_rd_c;
  logic [DATA_W-1:0] stage0_q, stage0_d, stage1_q, stage1_d;
  logic        v0_q, v0_d, v1_q, v1_d;
  logic        bus_conflict_d, prog_wr_err_d;

  assign main_addr_c = mem_addr[MAIN_ADDR_W-1:0];
  assign fb_addr_c   = mem_addr[FB_ADDR_W-1:0];
  assign prog_addr_c = mem_addr[PROG_ADDR_W-1:0];
  assign chunk_c     = mem_addr[15:14];
  assign cstk_addr_c = call_stk_addr[CSTK_ADDR_W-1:0];
  assign en_cnt_c    = 3'(call_stk_en) + 3'(main_mem_en) + 3'(fb_en) + 3'(prog_mem_en);

  // Data-port arbitration and program-word staging
  always_comb begin
    rd_src_c       = RD_NONE;
    main_we_c      = 1'b0;
    fb_we_c        = 1'b0;
    prog_we_c      = 1'b0;
    cstk_we_c      = 1'b0;
    cstk_rd_c      = 1'b0;
    stage0_d       = stage0_q;
    stage1_d       = stage1_q;
    v0_d           = v0_q;
    v1_d           = v1_q;
    prog_wr_err_d  = 1'b0;
    bus_conflict_d = (en_cnt_c > 3'd1);
    if (call_stk_en) begin
      cstk_we_c = mem_wen;
      cstk_rd_c = ~mem_wen;
    end else if (main_mem_en) begin
      main_we_c = mem_wen;
      if (!mem_wen) rd_src_c = RD_MAIN;
    end else if (fb_en) begin
      fb_we_c = mem_wen;
      if (!mem_wen) rd_src_c = RD_FB;
    end else if (prog_mem_en) begin
      if (!mem_wen) begin
        rd_src_c = RD_PROG;
      end else begin
        case (chunk_c)
          2'd0: begin
            stage0_d = write_data;
            v0_d     = 1'b1;
          end
          2'd1: begin
            stage1_d = write_data;
            v1_d     = 1'b1;
          end
          2'd2: begin
            prog_we_c     = v0_q & v1_q;
            prog_wr_err_d = ~(v0_q & v1_q);
            v0_d          = 1'b0;
            v1_d          = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (main_we_c) main_mem[main_addr_c] <= write_data;
  end

  always_ff @(posedge clock) begin
    if (fb_we_c) fb_mem[fb_addr_c] <= write_data;
  end

  always_ff @(posedge clock) begin
    if (prog_we_c) prog_mem[prog_addr_c] <= {write_data[7:0], stage1_q, stage0_q};
  end

  always_ff @(posedge clock) begin
    if (cstk_we_c) cstk_mem[cstk_addr_c] <= call_stk_write_data;
  end

  // Registered read ports; arrays are read with old contents on a same-edge write
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      mem_fetch_instruction <= '0;
      video_data            <= '0;
      read_data             <= '0;
      call_stk_read_data    <= '0;
      bus_conflict          <= 1'b0;
      prog_wr_err           <= 1'b0;
      stage0_q              <= '0;
      stage1_q              <= '0;
      v0_q                  <= 1'b0;
      v1_q                  <= 1'b0;
    end else begin
      mem_fetch_instruction <= prog_mem[prog_cntr_val[PROG_ADDR_W-1:0]];
      video_data            <= fb_mem[video_addr];
      bus_conflict          <= bus_conflict_d;
      prog_wr_err           <= prog_wr_err_d;
      stage0_q              <= stage0_d;
      stage1_q              <= stage1_d;
      v0_q                  <= v0_d;
      v1_q                  <= v1_d;
      if (cstk_rd_c) call_stk_read_data <= cstk_mem[cstk_addr_c];
      case (rd_src_c)
        RD_MAIN: read_data <= main_mem[main_addr_c];
        RD_FB:   read_data <= fb_mem[fb_addr_c];
        RD_PROG: begin
          case (chunk_c)
            2'd0:    read_data <= prog_mem[prog_addr_c][11:0];
            2'd1:    read_data <= prog_mem[prog_addr_c][23:12];
            2'd2:    read_data <= {4'b0000, prog_mem[prog_addr_c][31:24]};
            default: read_data <= '0;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_unit.sv
// Directed bench for mem_io_unit: stimulus pushes timed expectations into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_mem_io_unit;

  logic        clock = 1'b0;
  logic        nreset;
  logic [13:0] prog_cntr_val;
  logic [31:0] mem_fetch_instruction;
  logic        main_mem_en, prog_mem_en, fb_en, call_stk_en, mem_wen;
  logic [15:0] mem_addr;
  logic [11:0] write_data, read_data;
  logic [7:0]  call_stk_addr;
  logic [13:0] call_stk_write_data, call_stk_read_data;
  logic [13:0] video_addr;
  logic [11:0] video_data;
  logic        bus_conflict, prog_wr_err;

  mem_io_unit dut (
    .clock                 (clock),
    .nreset                (nreset),
    .prog_cntr_val         (prog_cntr_val),
    .mem_fetch_instruction (mem_fetch_instruction),
    .main_mem_en           (main_mem_en),
    .prog_mem_en           (prog_mem_en),
    .fb_en                 (fb_en),
    .call_stk_en           (call_stk_en),
    .mem_wen               (mem_wen),
    .mem_addr              (mem_addr),
    .write_data            (write_data),
    .read_data             (read_data),
    .call_stk_addr         (call_stk_addr),
    .call_stk_write_data   (call_stk_write_data),
    .call_stk_read_data    (call_stk_read_data),
    .video_addr            (video_addr),
    .video_data            (video_data),
    .bus_conflict          (bus_conflict),
    .prog_wr_err           (prog_wr_err)
  );

  always #5 clock = ~clock;

  localparam int K_RD = 0, K_CS = 1, K_FETCH = 2, K_VID = 3, K_CONF = 4, K_ERR = 5;

  typedef struct {
    int          kind;
    logic [31:0] val;
    int          at;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_RD:    return {20'd0, read_data};
      K_CS:    return {18'd0, call_stk_read_data};
      K_FETCH: return mem_fetch_instruction;
      K_VID:   return {20'd0, video_data};
      K_CONF:  return {31'd0, bus_conflict};
      default: return {31'd0, prog_wr_err};
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle; overdue ones count as missed
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        logic [31:0] a;
        a = actual(sb[i].kind);
        total++;
        if (sb[i].at < cyc) begin
          bad++;
          $display("FAIL %s: MISSED, due cycle %0d, now %0d", sb[i].name, sb[i].at, cyc);
        end else if (a !== sb[i].val) begin
          bad++;
          $display("FAIL %s: got %h want %h (cycle %0d)", sb[i].name, a, sb[i].val, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic check_reset_state(input string nm);
    total++;
    if (read_data !== 12'h000 || call_stk_read_data !== 14'h0000 ||
        mem_fetch_instruction !== 32'h0 || video_data !== 12'h000 ||
        bus_conflict !== 1'b0 || prog_wr_err !== 1'b0) begin
      bad++;
      $display("FAIL %s: outputs not cleared rd=%h cs=%h f=%h v=%h c=%b e=%b", nm,
               read_data, call_stk_read_data, mem_fetch_instruction, video_data,
               bus_conflict, prog_wr_err);
    end
  endtask

  task automatic expect_at(input int k, input logic [31:0] v, input int dc, input string nm);
    exp_t e;
    e.kind = k; e.val = v; e.at = cyc + dc; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic cs, input logic mm, input logic fb, input logic pm,
                      input logic we, input logic [15:0] a, input logic [11:0] wd);
    @(posedge clock); #1;
    call_stk_en = cs; main_mem_en = mm; fb_en = fb; prog_mem_en = pm;
    mem_wen = we; mem_addr = a; write_data = wd;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 16'h0000, 12'h000);
  endtask

  initial begin
    nreset = 1'b0;
    prog_cntr_val = '0; call_stk_addr = '0; call_stk_write_data = '0; video_addr = '0;
    call_stk_en = 0; main_mem_en = 0; fb_en = 0; prog_mem_en = 0; mem_wen = 0;
    mem_addr = '0; write_data = '0;

    idle();
    check_reset_state("rst_state");
    expect_at(K_RD, 0, 0, "rst_read_data");
    expect_at(K_CS, 0, 0, "rst_cstk_data");
    expect_at(K_FETCH, 0, 0, "rst_fetch");
    expect_at(K_VID, 0, 0, "rst_video");
    expect_at(K_CONF, 0, 0, "rst_conflict");
    expect_at(K_ERR, 0, 0, "rst_prog_err");
    idle();
    nreset = 1'b1;

    // Preload known pixels, then main write/read with hold
    step(0, 0, 1, 0, 1, 16'h0010, 12'h0AA);
    step(0, 0, 1, 0, 1, 16'h0200, 12'h123);
    step(0, 1, 0, 0, 1, 16'h0123, 12'hABC);
    video_addr = 14'h0200;
    expect_at(K_VID, 32'h123, 1, "video_preload");
    step(0, 1, 0, 0, 0, 16'h0123, 12'h000);
    expect_at(K_RD, 32'hABC, 1, "main_read");
    expect_at(K_CONF, 0, 1, "no_conflict");
    for (int i = 0; i < 3; i++) begin
      idle();
      expect_at(K_RD, 32'hABC, 1, "main_hold");
    end

    // Three-chunk program write and fetch
    step(0, 0, 0, 1, 1, 16'h0040, 12'h111);
    step(0, 0, 0, 1, 1, 16'h4040, 12'h222);
    step(0, 0, 0, 1, 1, 16'h8040, 12'h0C3);
    expect_at(K_ERR, 0, 1, "commit_no_err");
    idle();
    prog_cntr_val = 14'h0040;
    expect_at(K_FETCH, 32'hC3222111, 1, "fetch_new_word");
    step(0, 0, 0, 1, 0, 16'h4040, 12'h000);
    expect_at(K_RD, 32'h222, 1, "prog_rd_chunk1");
    step(0, 0, 0, 1, 0, 16'h8040, 12'h000);
    expect_at(K_RD, 32'h0C3, 1, "prog_rd_chunk2");
    step(0, 0, 0, 1, 0, 16'hC040, 12'h000);
    expect_at(K_RD, 32'h000, 1, "prog_rd_chunk3");

    // Commit without chunk 0 staged
    step(0, 0, 0, 1, 1, 16'h4040, 12'h333);
    step(0, 0, 0, 1, 1, 16'h8040, 12'h0FF);
    expect_at(K_ERR, 1, 1, "prog_err_pulse");
    expect_at(K_ERR, 0, 2, "prog_err_one_cycle");
    idle();
    expect_at(K_FETCH, 32'hC3222111, 1, "fetch_unchanged");

    // Call stack push and pop
    call_stk_addr = 8'h05; call_stk_write_data = 14'h2ABC;
    step(1, 0, 0, 0, 1, 16'h0000, 12'h000);
    step(1, 0, 0, 0, 0, 16'h0000, 12'h000);
    expect_at(K_CS, 32'h2ABC, 1, "cstk_pop");

    // Conflicting enables: main wins over fb
    step(0, 1, 1, 0, 1, 16'h0010, 12'h555);
    expect_at(K_CONF, 1, 1, "conflict_pulse");
    expect_at(K_CONF, 0, 2, "conflict_one_cycle");
    step(0, 1, 0, 0, 0, 16'h0010, 12'h000);
    expect_at(K_RD, 32'h555, 1, "main_won");
    step(0, 0, 1, 0, 0, 16'h0010, 12'h000);
    expect_at(K_RD, 32'h0AA, 1, "fb_untouched");
    step(1, 1, 0, 0, 0, 16'h0123, 12'h000);
    expect_at(K_CS, 32'h2ABC, 1, "cstk_priority");
    expect_at(K_RD, 32'h0AA, 1, "loser_no_read");
    expect_at(K_CONF, 1, 1, "conflict_cstk_main");

    // Video collision with a data-port fb write
    step(0, 0, 1, 0, 1, 16'h0200, 12'hFFF);
    expect_at(K_VID, 32'h123, 1, "video_old_pixel");
    expect_at(K_VID, 32'hFFF, 2, "video_new_pixel");
    idle();

    // Reset mid-staging discards partial program word
    step(0, 0, 0, 1, 1, 16'h0041, 12'h001);
    step(0, 0, 0, 1, 1, 16'h4041, 12'h002);
    idle();
    nreset = 1'b0;
    #1;
    check_reset_state("mid_rst_state");
    expect_at(K_RD, 0, 0, "mid_rst_read_data");
    expect_at(K_CS, 0, 0, "mid_rst_cstk");
    expect_at(K_FETCH, 0, 0, "mid_rst_fetch");
    expect_at(K_VID, 0, 0, "mid_rst_video");
    idle();
    nreset = 1'b1;
    expect_at(K_VID, 32'hFFF, 1, "video_after_rst");
    expect_at(K_FETCH, 32'hC3222111, 1, "fetch_after_rst");
    expect_at(K_RD, 0, 1, "read_data_after_rst");
    step(0, 0, 0, 1, 1, 16'h8041, 12'h0AB);
    expect_at(K_ERR, 1, 1, "staged_lost_err");

    for (int i = 0; i < 5; i++) idle();
    if (sb.size() != 0) begin
      bad += sb.size();
      $display("FAIL expired_wait: %0d expectation(s) never checked", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
